// File: rtl/traceif_ctrl.sv
// Lock supervisor and width scanner for the trace input interface.
// Steps through widths until sync is seen, holds lock, and recovers on silence.
module traceif_ctrl #(
  parameter int RSTCYCLES = 4,
  parameter int TIMEOUT   = 100000,
  parameter int LOSSTIME  = 1000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic       autoWidth,
  input  logic [1:0] reqWidth,
  input  logic       rescan,
  input  logic       syncSeen,
  output logic [1:0] width,
  output logic       ifRst,
  output logic       locked,
  output logic       scanning,
  output logic       scanFail,
  output logic [7:0] lossCount
);

  localparam int MAXA = (TIMEOUT > LOSSTIME) ? TIMEOUT : LOSSTIME;
  localparam int MAXP = (MAXA > RSTCYCLES) ? MAXA : RSTCYCLES;
  localparam int CW   = $clog2(MAXP);

  localparam logic [CW-1:0] RST_LAST  = CW'(RSTCYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] LOSS_LAST = CW'(LOSSTIME - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RESET  = 2'd1,
    S_WAIT   = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    width_q, width_d;
  logic          auto_q, auto_d;
  logic          fail_q, fail_d;
  logic [7:0]    loss_q, loss_d;
  logic          ifrst_q, locked_q, scanning_q;
  logic          enter;
  logic [1:0]    start_width;

  assign start_width = autoWidth ? 2'd3 : reqWidth;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      width_q    <= 2'd3;
      auto_q     <= 1'b1;
      fail_q     <= 1'b0;
      loss_q     <= 8'd0;
      ifrst_q    <= 1'b1;
      locked_q   <= 1'b0;
      scanning_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      width_q    <= width_d;
      auto_q     <= auto_d;
      fail_q     <= fail_d;
      loss_q     <= loss_d;
      // Flags are registered from the next state so they never glitch.
      ifrst_q    <= (state_d == S_IDLE) || (state_d == S_RESET);
      locked_q   <= (state_d == S_LOCKED);
      scanning_q <= (state_d == S_RESET) || (state_d == S_WAIT);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    width_d = width_q;
    auto_d  = auto_q;
    fail_d  = fail_q;
    loss_d  = loss_q;
    enter   = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      enter   = 1'b1;
    end else if (rescan && (state_q != S_IDLE)) begin
      state_d = S_RESET;
      enter   = 1'b1;
      width_d = start_width;
      auto_d  = autoWidth;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RESET;
          enter   = 1'b1;
          width_d = start_width;
          auto_d  = autoWidth;
          fail_d  = 1'b0;
        end
        S_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT;
            enter   = 1'b1;
          end
        end
        S_WAIT: begin
          if (syncSeen) begin
            state_d = S_LOCKED;
            enter   = 1'b1;
            fail_d  = 1'b0;
          end else if (cnt_q == TO_LAST) begin
            state_d = S_RESET;
            enter   = 1'b1;
            if (auto_q && (width_q > 2'd1)) begin
              width_d = width_q - 2'd1;
            end else begin
              // A whole pass failed; auto mode wraps back to the widest bus.
              fail_d = 1'b1;
              if (auto_q) width_d = 2'd3;
            end
          end
        end
        S_LOCKED: begin
          if (syncSeen) begin
            cnt_d = '0;
          end else if (cnt_q == LOSS_LAST) begin
            state_d = S_RESET;
            enter   = 1'b1;
            loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          enter   = 1'b1;
        end
      endcase
    end
    if (enter) cnt_d = '0;
  end

  assign width     = width_q;
  assign ifRst     = ifrst_q;
  assign locked    = locked_q;
  assign scanning  = scanning_q;
  assign scanFail  = fail_q;
  assign lossCount = loss_q;

endmodule

// File: tb/tb_traceif_ctrl.sv
// Directed bench for traceif_ctrl with short timers (RSTCYCLES=4, TIMEOUT=20, LOSSTIME=50).
module tb_traceif_ctrl;
  logic       clk = 1'b0;
  logic       rstn;
  logic       enable;
  logic       autoWidth;
  logic [1:0] reqWidth;
  logic       rescan;
  logic       syncSeen;
  logic [1:0] width;
  logic       ifRst;
  logic       locked;
  logic       scanning;
  logic       scanFail;
  logic [7:0] lossCount;

  int n_cmp = 0;
  int n_err = 0;

  traceif_ctrl #(.RSTCYCLES(4), .TIMEOUT(20), .LOSSTIME(50)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .autoWidth(autoWidth),
    .reqWidth(reqWidth), .rescan(rescan), .syncSeen(syncSeen),
    .width(width), .ifRst(ifRst), .locked(locked), .scanning(scanning),
    .scanFail(scanFail), .lossCount(lossCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_sync();
    syncSeen = 1'b1;
    tick();
    syncSeen = 1'b0;
  endtask

  task automatic test_reset();
    // vector: width, ifRst, locked, scanning, scanFail, lossCount
    n_cmp++;
    if ({width, ifRst, locked, scanning, scanFail, lossCount} !== {2'd3, 4'b1000, 8'd0}) begin
      n_err++;
      $display("FAIL reset_values: got %h want %h",
               {width, ifRst, locked, scanning, scanFail, lossCount}, {2'd3, 4'b1000, 8'd0});
    end
    rstn = 1'b1; enable = 1'b1; autoWidth = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) begin
        n_cmp++;
        if (scanning !== 1'b1) begin
          n_err++; $display("FAIL reset_scanning_latency: got %b want 1", scanning);
        end
      end
      n_cmp++;
      if ({ifRst, width} !== 3'b111) begin
        n_err++; $display("FAIL reset_rst_hold[%0d]: got ifRst=%b width=%0d want ifRst=1 width=3", k, ifRst, width);
      end
    end
    tick();
    n_cmp++;
    if ({ifRst, scanning} !== 2'b01) begin
      n_err++; $display("FAIL reset_wait_entry: got ifRst=%b scanning=%b want 0 1", ifRst, scanning);
    end
    ticks(4);
    pulse_sync();
    n_cmp++;
    if ({locked, scanFail, ifRst, scanning} !== 4'b1000) begin
      n_err++; $display("FAIL reset_lock: got locked=%b scanFail=%b ifRst=%b scanning=%b want 1 0 0 0",
                        locked, scanFail, ifRst, scanning);
    end
    $display("test_reset done");
  endtask

  task automatic test_auto_scan();
    enable = 1'b0;
    tick();
    n_cmp++;
    if ({ifRst, locked, scanning} !== 3'b100) begin
      n_err++; $display("FAIL auto_idle: got %b want 100", {ifRst, locked, scanning});
    end
    enable = 1'b1;
    tick();
    n_cmp++;
    if ({width, ifRst} !== 3'b111) begin
      n_err++; $display("FAIL auto_start: got width=%0d ifRst=%b want 3 1", width, ifRst);
    end
    ticks(23);
    n_cmp++;
    if ({width, ifRst} !== 3'b110) begin
      n_err++; $display("FAIL auto_last_wait: got width=%0d ifRst=%b want 3 0", width, ifRst);
    end
    tick();
    n_cmp++;
    if ({width, ifRst, scanFail} !== 4'b1010) begin
      n_err++; $display("FAIL auto_w2: got width=%0d ifRst=%b scanFail=%b want 2 1 0", width, ifRst, scanFail);
    end
    ticks(24);
    n_cmp++;
    if ({width, ifRst, scanFail} !== 4'b0110) begin
      n_err++; $display("FAIL auto_w1: got width=%0d ifRst=%b scanFail=%b want 1 1 0", width, ifRst, scanFail);
    end
    ticks(24);
    n_cmp++;
    if ({width, ifRst, scanFail} !== 4'b1111) begin
      n_err++; $display("FAIL auto_wrap: got width=%0d ifRst=%b scanFail=%b want 3 1 1", width, ifRst, scanFail);
    end
    ticks(6);
    pulse_sync();
    n_cmp++;
    if ({locked, scanFail, width} !== 4'b1011) begin
      n_err++; $display("FAIL auto_relock: got locked=%b scanFail=%b width=%0d want 1 0 3", locked, scanFail, width);
    end
    $display("test_auto_scan done");
  endtask

  task automatic test_fixed();
    enable = 1'b0;
    tick();
    autoWidth = 1'b0; reqWidth = 2'd2; enable = 1'b1;
    tick();
    n_cmp++;
    if ({width, ifRst} !== 3'b101) begin
      n_err++; $display("FAIL fixed_start: got width=%0d ifRst=%b want 2 1", width, ifRst);
    end
    // Mid-pass changes must be ignored until the next pass start.
    reqWidth = 2'd1; autoWidth = 1'b1;
    ticks(24);
    n_cmp++;
    if ({width, ifRst, scanFail} !== 4'b1011) begin
      n_err++; $display("FAIL fixed_retry: got width=%0d ifRst=%b scanFail=%b want 2 1 1", width, ifRst, scanFail);
    end
    ticks(23);
    n_cmp++;
    if ({width, ifRst, locked} !== 4'b1000) begin
      n_err++; $display("FAIL fixed_pre_timeout: got width=%0d ifRst=%b locked=%b want 2 0 0", width, ifRst, locked);
    end
    pulse_sync();
    n_cmp++;
    if ({locked, ifRst, scanFail, width} !== 5'b10010) begin
      n_err++; $display("FAIL fixed_sync_at_timeout: got locked=%b ifRst=%b scanFail=%b width=%0d want 1 0 0 2",
                        locked, ifRst, scanFail, width);
    end
    $display("test_fixed done");
  endtask

  task automatic test_loss();
    int exp_loss;
    for (int r = 0; r < 3; r++) begin
      ticks(39);
      pulse_sync();
      n_cmp++;
      if (locked !== 1'b1) begin
        n_err++; $display("FAIL loss_hold[%0d]: got locked=%b want 1", r, locked);
      end
    end
    ticks(49);
    n_cmp++;
    if ({locked, lossCount} !== {1'b1, 8'd0}) begin
      n_err++; $display("FAIL loss_pre: got locked=%b lossCount=%0d want 1 0", locked, lossCount);
    end
    tick();
    n_cmp++;
    if ({locked, ifRst, scanning, width, lossCount} !== {3'b011, 2'd2, 8'd1}) begin
      n_err++; $display("FAIL loss_first: got locked=%b ifRst=%b scanning=%b width=%0d lossCount=%0d want 0 1 1 2 1",
                        locked, ifRst, scanning, width, lossCount);
    end
    exp_loss = 1;
    for (int i = 2; i <= 300; i++) begin
      ticks(4);
      pulse_sync();
      ticks(50);
      exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
      n_cmp++;
      if (lossCount !== exp_loss[7:0]) begin
        n_err++; $display("FAIL loss_count[%0d]: got %0d want %0d", i, lossCount, exp_loss);
      end
    end
    $display("test_loss done lossCount=%0d", lossCount);
  endtask

  task automatic test_rescan();
    ticks(4);
    pulse_sync();
    n_cmp++;
    if (locked !== 1'b1) begin
      n_err++; $display("FAIL rescan_locked: got %b want 1", locked);
    end
    rescan = 1'b1; enable = 1'b0;
    tick();
    rescan = 1'b0;
    n_cmp++;
    if ({ifRst, locked, scanning, lossCount} !== {3'b100, 8'd255}) begin
      n_err++; $display("FAIL rescan_disable: got ifRst=%b locked=%b scanning=%b lossCount=%0d want 1 0 0 255",
                        ifRst, locked, scanning, lossCount);
    end
    autoWidth = 1'b1; enable = 1'b1;
    tick();
    ticks(48);
    ticks(9);
    n_cmp++;
    if ({width, ifRst} !== 3'b010) begin
      n_err++; $display("FAIL rescan_mid_wait: got width=%0d ifRst=%b want 1 0", width, ifRst);
    end
    rescan = 1'b1;
    tick();
    rescan = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      n_cmp++;
      if ({width, ifRst} !== 3'b111) begin
        n_err++; $display("FAIL rescan_rst[%0d]: got width=%0d ifRst=%b want 3 1", k, width, ifRst);
      end
    end
    tick();
    n_cmp++;
    if (ifRst !== 1'b0) begin
      n_err++; $display("FAIL rescan_rst_end: got ifRst=%b want 0", ifRst);
    end
    $display("test_rescan done");
  endtask

  task automatic test_async_reset();
    autoWidth = 1'b0; reqWidth = 2'd2; rescan = 1'b1;
    tick();
    rescan = 1'b0;
    tick();
    n_cmp++;
    if ({width, ifRst, scanning} !== 4'b1011) begin
      n_err++; $display("FAIL async_pre: got width=%0d ifRst=%b scanning=%b want 2 1 1", width, ifRst, scanning);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({width, ifRst, locked, scanning, scanFail, lossCount} !== {2'd3, 4'b1000, 8'd0}) begin
      n_err++; $display("FAIL async_clear: got %h want %h",
                        {width, ifRst, locked, scanning, scanFail, lossCount}, {2'd3, 4'b1000, 8'd0});
    end
    tick();
    rstn = 1'b1;
    tick();
    n_cmp++;
    if ({width, ifRst, scanning, lossCount} !== {2'd2, 2'b11, 8'd0}) begin
      n_err++; $display("FAIL async_restart: got width=%0d ifRst=%b scanning=%b lossCount=%0d want 2 1 1 0",
                        width, ifRst, scanning, lossCount);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    rstn = 1'b1; enable = 1'b0; autoWidth = 1'b0; reqWidth = 2'd0;
    rescan = 1'b0; syncSeen = 1'b0;
    #2 rstn = 1'b0;
    ticks(2);
    test_reset();
    test_auto_scan();
    test_fixed();
    test_loss();
    test_rescan();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/traceif_ctrl.md
# traceif_ctrl

Lock supervisor and width scanner for the trace front end. It runs in the system clock domain and drives the width and reset inputs of the trace input interface. It watches that interface's sync indication: in auto mode it steps through the 4-, 2- and 1-bit widths until sync is found, then holds lock and recovers when sync goes silent. It also reports lock state, scan failure and a saturating count of sync losses to the host-facing registers.

## Interface
Parameters:
- `RSTCYCLES`, 4 — clocks `ifRst` is held high per interface reset (≥1)
- `TIMEOUT`, 100000 — clocks allowed per width attempt to see sync (≥2)
- `LOSSTIME`, 1000000 — clocks without sync while locked before lock is declared lost (≥2)

Ports:
- `clk`  in  1  system clock
- `rstn`  in  1  asynchronous active-low reset
- `enable`  in  1  level; 0 forces IDLE
- `autoWidth`  in  1  1 = scan widths 3→2→1; 0 = use `reqWidth` only
- `reqWidth`  in  2  fixed width code (0,1 = 1-bit, 2 = 2-bit, 3 = 4-bit)
- `rescan`  in  1  single-clock pulse; restart acquisition from the start width
- `syncSeen`  in  1  single-clock pulse per sync packet, already synchronised to `clk`
- `width`  out  2  width code to the trace interface
- `ifRst`  out  1  active-high reset to the trace interface, registered and glitch-free
- `locked`  out  1  sync acquired and held
- `scanning`  out  1  in RESET or WAIT
- `scanFail`  out  1  sticky; a full acquisition pass failed
- `lossCount`  out  8  saturating count of LOCKED→loss events

## Operation
- States: IDLE, RESET, WAIT, LOCKED. All outputs are registered.
- Start width: 3 if `autoWidth`, otherwise `reqWidth`. Both inputs are sampled only when a pass starts, which is on leaving IDLE or on `rescan`.
- **IDLE**
  - `ifRst`=1, `locked`=0, `scanning`=0.
  - `enable`=1 → RESET with `width`=start width, `scanFail` cleared.
- **RESET**
  - `ifRst`=1 for exactly RSTCYCLES clocks, then → WAIT.
- **WAIT**
  - `ifRst`=0; the timer counts clocks.
  - `syncSeen` → LOCKED; clears `scanFail`.
  - Timer reaches TIMEOUT with no sync, auto mode, `width`>1 → `width`−1, then → RESET.
  - Timer reaches TIMEOUT with no sync, auto mode, `width`≤1 → set `scanFail`, `width`=3, then → RESET. The scan repeats indefinitely.
  - Timer reaches TIMEOUT with no sync, fixed mode → set `scanFail`, then → RESET with the same width.
- **LOCKED**
  - `locked`=1; the silence timer restarts on every `syncSeen`.
  - Silence reaches LOSSTIME → `lossCount`+1 (saturating at 255), `locked`=0, then → RESET with the same width. Only after that retry times out does scanning continue as in WAIT.
- Priority within one clock: `enable`=0 > `rescan` > `syncSeen` > timer expiry.
  - `enable`=0 in any state → IDLE on the next clock, with `ifRst`=1 on that same clock.
  - `rescan` in RESET, WAIT or LOCKED → RESET with a freshly sampled start width. `rescan` in IDLE is ignored.
  - `syncSeen` on the same clock as TIMEOUT expiry → LOCKED.
- `syncSeen` is ignored in IDLE and RESET.
- Changing `reqWidth` or `autoWidth` mid-pass has no effect until the next pass start.
- `lossCount` is cleared only by `rstn`. `rescan` and `enable` do not clear it.
- Counters are sized with $clog2 of their parameter and have no wrap-around. Each counter is reset on every state entry.

## Timing
- Reset values: `width`=3, `ifRst`=1, `locked`=0, `scanning`=0, `scanFail`=0, `lossCount`=0, state IDLE.
- Latency from the triggering input to the next registered output is 1 clock:
  - `enable` rising → `scanning`=1.
  - `syncSeen` → `locked`=1.
  - `rescan` → `ifRst`=1.
- In RESET, `ifRst` is high for RSTCYCLES consecutive clocks. On the following clock `ifRst`=0.
- `width` changes only on the same clock that RESET is entered, so it is always stable while `ifRst`=0.
- TIMEOUT expiry: the WAIT→RESET transition occurs TIMEOUT clocks after WAIT entry.
- Loss: LOCKED→RESET occurs LOSSTIME clocks after the last `syncSeen`. `lossCount` updates on the same clock.
- `rstn` asserted mid-operation clears everything immediately (asynchronous). Deassertion restarts from IDLE.

## Test plan
- Reset with `enable`=1, `autoWidth`=1, RSTCYCLES=4, TIMEOUT=20, pulse `syncSeen` 5 clocks into WAIT → `ifRst` high for 4 clocks, `width`=3, `locked`=1 one clock after the pulse, `scanFail`=0.
- Auto mode with no `syncSeen` for 3×(4+20) clocks → `width` sequence 3,2,1, then 3 with `scanFail`=1. A later `syncSeen` clears `scanFail` and sets `locked`.
- Fixed mode, `reqWidth`=2, no sync → `width` stays 2 across retries and `scanFail`=1. `syncSeen` on the exact TIMEOUT clock → LOCKED, no RESET.
- LOCKED with LOSSTIME=50: syncs every 40 clocks hold lock; a 50-clock gap → `locked`=0, `lossCount`=1, re-RESET with unchanged `width`. Drive 300 losses → `lossCount` saturates at 255.
- `rescan` and `enable`=0 on the same clock in LOCKED → IDLE with `ifRst`=1. `rescan` alone mid-WAIT at `width`=1 → `width`=3 and `ifRst` high for 4 clocks.
- Assert `rstn` low mid-RESET → all outputs return to their reset values immediately, without waiting for a clock edge.
